des_engine_param: RTL and testbench

Parametrised, iterative DES block cipher engine (FIPS 46-3) with encrypt/decrypt selection per block, configurable loop unrolling, and an on-the-fly key schedule. It replaces the fixed one-round-per-cycle encrypt-only core. It sits between the host input buffer and the output buffer behind valid/ready handshakes on both sides. Each accepted block carries its own key and mode, so consecutive blocks need not share a key.

---
 rtl/des_engine_param.sv | 265 ++++++++++++++++++++++++++
 tb/tb_des_engine_param.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_engine_param.sv
// Iterative DES engine (encrypt/decrypt per block) with ROUNDS_PER_CYCLE unrolled Feistel rounds
// and rolling C/D key schedule. Define DES_PARITY_CHECK_EN to add the advisory key_err output.
module des_engine_param #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
`ifdef DES_PARITY_CHECK_EN
    ,
    output logic        key_err
`endif
);

    localparam int N_ITER = 16 / ROUNDS_PER_CYCLE;
    localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] LAST_CNT = 5'(16 - ROUNDS_PER_CYCLE);
    // Bit k set means encrypt round k+1 rotates C/D by two positions.
    localparam logic [15:0] SHIFT2 = 16'h7EFC;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16) || N_ITER * ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // S-boxes S1..S8, 64 entries each, indexed row*16 + column.
    localparam int S_T [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    // Tables use DES numbering: entry value p is bit p counted from the MSB (p = 1).
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-IP_T[j]];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-FP_T[j]];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[55-j] = x[64-PC1_T[j]];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[56-PC2_T[j]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        for (int j = 0; j < 48; j++) e[47-j] = r[32-E_T[j]];
        e = e ^ k;
        for (int n = 0; n < 8; n++) begin
            b = e[47-6*n -: 6];
            s[31-4*n -: 4] = 4'(S_T[n*64 + int'({b[5], b[0], b[4:1]})]);
        end
        for (int j = 0; j < 32; j++) y[31-j] = s[32-P_T[j]];
        return y;
    endfunction

    // Decrypt walks the encrypt schedule backwards with right rotations; round 1 is unrotated.
    function automatic logic [1:0] shift_amt(input logic [3:0] k, input logic dec);
        if (!dec) return SHIFT2[k] ? 2'd2 : 2'd1;
        if (k == 4'd0) return 2'd0;
        return SHIFT2[4'd0 - k] ? 2'd2 : 2'd1;
    endfunction

    function automatic logic [27:0] rotate(input logic [27:0] x, input logic [1:0] amt, input logic right);
        logic [27:0] y;
        case ({right, amt})
            3'b001:  y = {x[26:0], x[27]};
            3'b010:  y = {x[25:0], x[27:26]};
            3'b101:  y = {x[0], x[27:1]};
            3'b110:  y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

    state_t      state_reg;
    logic [31:0] l_reg, r_reg;
    logic [27:0] c_reg, d_reg;
    logic [4:0]  cnt_reg;
    logic        dec_reg;
    logic        out_valid_reg;
    logic [63:0] out_data_reg;
    logic [63:0] ip_data;
    logic [55:0] pc1_key;
    logic [31:0] l_last, r_last;
    logic [27:0] c_last, d_last;

    assign ip_data = perm_ip(in_data);
    assign pc1_key = perm_pc1(in_key);

    genvar gi;
    for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
        logic [31:0] l_in, r_in, l_out, r_out;
        logic [27:0] c_in, d_in, c_out, d_out;
        logic [3:0]  k;
        logic [1:0]  amt;
        if (gi == 0) begin : g_first
            assign l_in = l_reg;
            assign r_in = r_reg;
            assign c_in = c_reg;
            assign d_in = d_reg;
        end else begin : g_chain
            assign l_in = g_round[gi-1].l_out;
            assign r_in = g_round[gi-1].r_out;
            assign c_in = g_round[gi-1].c_out;
            assign d_in = g_round[gi-1].d_out;
        end
        assign k     = cnt_reg[3:0] + 4'(gi);
        assign amt   = shift_amt(k, dec_reg);
        assign c_out = rotate(c_in, amt, dec_reg);
        assign d_out = rotate(d_in, amt, dec_reg);
        assign l_out = r_in;
        assign r_out = l_in ^ feistel(r_in, perm_pc2({c_out, d_out}));
    end

    assign l_last = g_round[ROUNDS_PER_CYCLE-1].l_out;
    assign r_last = g_round[ROUNDS_PER_CYCLE-1].r_out;
    assign c_last = g_round[ROUNDS_PER_CYCLE-1].c_out;
    assign d_last = g_round[ROUNDS_PER_CYCLE-1].d_out;

`ifdef DES_PARITY_CHECK_EN
    logic [7:0] byte_odd;
    logic       key_err_reg;
    for (gi = 0; gi < 8; gi++) begin : g_parity
        assign byte_odd[gi] = ^in_key[8*gi +: 8];
    end
    assign key_err = key_err_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            l_reg         <= '0;
            r_reg         <= '0;
            c_reg         <= '0;
            d_reg         <= '0;
            cnt_reg       <= '0;
            dec_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
`ifdef DES_PARITY_CHECK_EN
            key_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    l_reg     <= ip_data[63:32];
                    r_reg     <= ip_data[31:0];
                    c_reg     <= pc1_key[55:28];
                    d_reg     <= pc1_key[27:0];
                    dec_reg   <= in_decrypt;
                    cnt_reg   <= '0;
                    state_reg <= ROUND;
`ifdef DES_PARITY_CHECK_EN
                    key_err_reg <= ~&byte_odd;
`endif
                end
                ROUND: begin
                    l_reg   <= l_last;
                    r_reg   <= r_last;
                    c_reg   <= c_last;
                    d_reg   <= d_last;
                    cnt_reg <= cnt_reg + STEP;
                    if (cnt_reg == LAST_CNT) begin
                        out_data_reg  <= perm_fp({r_last, l_last});
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end
                end
                OUT: if (out_ready) begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_des_engine_param.sv
// Directed bench for des_engine_param: one engine per legal ROUNDS_PER_CYCLE (1,2,4,8,16),
// known-answer DES vectors, backpressure and mid-block reset.
module tb_des_engine_param;

    localparam int NU = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid   [NU];
    logic        in_decrypt [NU];
    logic [63:0] in_data    [NU];
    logic [63:0] in_key     [NU];
    logic        out_ready  [NU];
    logic        in_ready   [NU];
    logic        out_valid  [NU];
    logic        busy       [NU];
    logic [63:0] out_data   [NU];
`ifdef DES_PARITY_CHECK_EN
    logic        key_err    [NU];
`endif

    int total = 0;
    int bad = 0;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2 = 64'h8787878787878787;
    localparam logic [63:0] C2 = 64'h0000000000000000;
    localparam logic [63:0] C0 = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0] CF = 64'h7359B2163E4EDC58;

    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < NU; gi++) begin : g_dut
        des_engine_param #(.ROUNDS_PER_CYCLE(1 << gi)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid[gi]),
            .in_ready   (in_ready[gi]),
            .in_decrypt (in_decrypt[gi]),
            .in_data    (in_data[gi]),
            .in_key     (in_key[gi]),
            .out_valid  (out_valid[gi]),
            .out_ready  (out_ready[gi]),
            .out_data   (out_data[gi]),
            .busy       (busy[gi])
`ifdef DES_PARITY_CHECK_EN
            ,
            .key_err    (key_err[gi])
`endif
        );
    end

    // One block through engine u: offer, time the result, check it, complete the handshake.
    task automatic run_block(input int u, input logic dec, input logic [63:0] key,
                             input logic [63:0] data, input logic [63:0] exp);
        int lat;
        int nexp;
        nexp = 16 >> u;
        @(negedge clk);
        total++;
        if (in_ready[u] !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready u=%0d got=%b want=1", u, in_ready[u]);
        end
        in_valid[u] = 1'b1; in_decrypt[u] = dec; in_key[u] = key; in_data[u] = data; out_ready[u] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[u] = 1'b0;
        total++;
        if (in_ready[u] !== 1'b0 || busy[u] !== 1'b1) begin
            bad++;
            $display("FAIL accept u=%0d in_ready=%b busy=%b want 0/1", u, in_ready[u], busy[u]);
        end
        lat = 0;
        while (out_valid[u] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        total++;
        if (lat != nexp) begin
            bad++;
            $display("FAIL latency u=%0d got=%0d want=%0d", u, lat, nexp);
        end
        total++;
        if (out_data[u] !== exp) begin
            bad++;
            $display("FAIL data u=%0d got=%h want=%h", u, out_data[u], exp);
        end
        $display("block rpc=%0d dec=%b key=%h in=%h out=%h lat=%0d", 1 << u, dec, key, data, out_data[u], lat);
        out_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[u] = 1'b0;
        total++;
        if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1 || out_data[u] !== exp) begin
            bad++;
            $display("FAIL handshake u=%0d out_valid=%b in_ready=%b data=%h want 0/1/%h",
                     u, out_valid[u], in_ready[u], out_data[u], exp);
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < NU; u++) begin
            in_valid[u] = 1'b0; in_decrypt[u] = 1'b0; in_data[u] = '0; in_key[u] = '0; out_ready[u] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int u = 0; u < NU; u++) begin
            total++;
            if (out_valid[u] !== 1'b0 || out_data[u] !== 64'h0 || in_ready[u] !== 1'b1 || busy[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset u=%0d out_valid=%b out_data=%h in_ready=%b busy=%b want 0/0/1/0",
                         u, out_valid[u], out_data[u], in_ready[u], busy[u]);
            end
`ifdef DES_PARITY_CHECK_EN
            total++;
            if (key_err[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_key_err u=%0d got=%b want=0", u, key_err[u]);
            end
`endif
        end
    endtask

    task automatic test_encrypt();
        run_block(0, 1'b0, K1, P1, C1);
    endtask

    task automatic test_decrypt();
        run_block(0, 1'b1, K1, C1, P1);
    endtask

    task automatic test_unroll();
        for (int u = 0; u < NU; u++) begin
            run_block(u, 1'b0, K2, P2, C2);
            run_block(u, 1'b1, K2, C2, P2);
        end
        run_block(4, 1'b0, 64'h0, 64'h0, C0);
        run_block(2, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, CF);
        run_block(3, 1'b1, K1, C1, P1);
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        in_valid[0] = 1'b1; in_decrypt[0] = 1'b0; in_key[0] = K1; in_data[0] = P1; out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Second block waits on the inputs for the whole of the first block.
        in_decrypt[0] = 1'b1; in_data[0] = C1;
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        total++;
        if (lat != 16 || out_data[0] !== C1) begin
            bad++;
            $display("FAIL bp_first lat=%0d data=%h want 16/%h", lat, out_data[0], C1);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_data[0] !== C1 || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall cyc=%0d data=%h valid=%b in_ready=%b want %h/1/0",
                         i, out_data[0], out_valid[0], in_ready[0], C1);
            end
        end
        $display("block rpc=1 stalled 10 cycles out=%h", out_data[0]);
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
        total++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready[0], out_valid[0]);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        total++;
        if (in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_second_accept in_ready=%b busy=%b want 0/1", in_ready[0], busy[0]);
        end
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        total++;
        if (lat != 16 || out_data[0] !== P1) begin
            bad++;
            $display("FAIL bp_second lat=%0d data=%h want 16/%h", lat, out_data[0], P1);
        end
        $display("block rpc=1 dec=1 key=%h in=%h out=%h lat=%0d", K1, C1, out_data[0], lat);
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid[0] = 1'b1; in_decrypt[0] = 1'b0; in_key[0] = K2; in_data[0] = P1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int u = 0; u < NU; u++) begin
            total++;
            if (out_valid[u] !== 1'b0 || out_data[u] !== 64'h0 || busy[u] !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset u=%0d out_valid=%b out_data=%h busy=%b want 0/0/0",
                         u, out_valid[u], out_data[u], busy[u]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_ready got=%b want=1", in_ready[0]);
        end
        $display("block rpc=1 aborted by reset at round 7");
        run_block(0, 1'b0, K1, P1, C1);
    endtask

`ifdef DES_PARITY_CHECK_EN
    task automatic test_parity();
        run_block(0, 1'b0, 64'h0, 64'h0, C0);
        total++;
        if (key_err[0] !== 1'b1) begin
            bad++;
            $display("FAIL parity_zero_key got=%b want=1", key_err[0]);
        end
        run_block(1, 1'b0, K1, P1, C1);
        total++;
        if (key_err[1] !== 1'b0) begin
            bad++;
            $display("FAIL parity_good_key got=%b want=0", key_err[1]);
        end
        run_block(0, 1'b0, 64'h0101010101010101, 64'h0, C0);
        total++;
        if (key_err[0] !== 1'b0) begin
            bad++;
            $display("FAIL parity_odd_key got=%b want=0", key_err[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_unroll();
        test_back_to_back();
        test_reset_mid();
`ifdef DES_PARITY_CHECK_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
